flow_route_scheduler: RTL
=========================

// Module: flow_route_scheduler
// PURPOSE
//  Time-shares the planar switch network (Switch instances feeding Mixer/Heater/Filter
//  stages) between NUM_REQ protocol requesters. Round-robin arbitrates route requests,
//  drives the switch port-select/enable lines, waits for valve settling, holds the route
//  for a per-request dwell time, then releases. Sits between protocol sequencers and valve drivers.
// PARAMETERS
//  NUM_REQ     4   number of requesters
//  NUM_SW      8   switches in the network
//  SEL_W       2   port-select bits per switch (4 ports)
//  TIMER_W     16  width of dwell and settle counters
//  SETTLE_CYC  16  valve actuation settle time in cycles (>=1)
// PORTS
//  clk         in   1                   system clock
//  rst_n       in   1                   reset
//  req         in   NUM_REQ             route request, level, held until done
//  req_route   in   NUM_REQ*NUM_SW*SEL_W per-requester switch port selects, req i at [i*NUM_SW*SEL_W +: NUM_SW*SEL_W]
//  req_sw_mask in   NUM_REQ*NUM_SW      per-requester switches used by route
//  req_dwell   in   NUM_REQ*TIMER_W     per-requester dwell cycles
//  grant       out  NUM_REQ             one-hot owner of the network
//  route_ready out  1                   route settled, fluid may flow
//  done        out  NUM_REQ             one-cycle completion pulse to owner
//  sw_sel      out  NUM_SW*SEL_W        switch port selects to valve drivers
//  sw_en       out  NUM_SW              switch actuate enables
//  busy        out  1                   network owned (state != IDLE)
// BEHAVIOUR
//  - One clock domain: clk. rst_n asynchronous, active-low; deassertion is synchronised externally.
//  - Reset: grant=0, done=0, route_ready=0, busy=0, sw_sel=0, sw_en=0, rr pointer=0, state=IDLE.
//  - FSM: IDLE -> SETTLE -> DWELL -> RELEASE (-> PURGE if PURGE_EN) -> IDLE.
//  - IDLE: if |req, pick first set bit at or after rr pointer (wrapping). Next edge: grant one-hot,
//    busy=1, sw_sel/sw_en loaded from winner's req_route/req_sw_mask, dwell latched; state=SETTLE.
//    Unmasked switches: sw_sel=0, sw_en=0. Inputs changing after latch are ignored.
//  - SETTLE: counter runs SETTLE_CYC cycles; route_ready=1 from the following cycle; state=DWELL.
//  - DWELL: counts latched dwell cycles with route_ready=1; dwell=0 treated as 1.
//  - RELEASE (1 cycle): done[owner]=1, grant=0, route_ready=0, sw_en=0, sw_sel=0; rr pointer=owner+1
//    mod NUM_REQ; state=IDLE (or PURGE). Grant-to-done latency = 1+SETTLE_CYC+max(dwell,1) cycles.
//  - Abort: owner drops req in SETTLE or DWELL -> next edge goes to RELEASE. done still pulses.
//  - Requester must drop req on the cycle after done. Req still high in IDLE is a new request.
//  - No back-to-back grant: at least one IDLE cycle between RELEASE and next grant.
//  - Simultaneous requests: strict round-robin from pointer. No requester waits more than
//    NUM_REQ-1 grants.
//  - Counters saturate, never wrap. Dwell is TIMER_W bits unsigned.
//  - Reset mid-operation: immediately clears all outputs (valves close); no done pulse.
// CONFIGURATION
//  FLOW_ROUTE_PURGE_EN defined: after RELEASE, enter PURGE for SETTLE_CYC cycles with
//    sw_en=0, busy=1, grant=0 before IDLE, so valves fully close between owners.
//  Undefined: RELEASE goes straight to IDLE; busy drops in the cycle after RELEASE.
// TESTING
//  1 reset: assert rst_n=0 mid-DWELL -> same-cycle sw_en=0, grant=0, route_ready=0, no done.
//  2 single req[0], dwell=5, SETTLE_CYC=16: grant[0] next cycle, route_ready 17 cycles later,
//    high 5 cycles, then done[0] one cycle, sw_en=0.
//  3 req=4'b1111 held: grants in order 0,1,2,3,0. Each grant after done+1 IDLE cycle.
//  4 req[2] dropped 3 cycles into DWELL (dwell=100): RELEASE next edge, done[2] pulses, rr=3.
//  5 dwell=0: exactly 1 DWELL cycle; req_sw_mask=8'h05 -> sw_en=8'h05, unmasked selects 0.
//  6 FLOW_ROUTE_PURGE_EN: back-to-back reqs -> SETTLE_CYC cycles busy=1, sw_en=0 between grants.

Source files
------------

// File: rtl/flow_route_scheduler.sv
// Round-robin owner of the switch network: grants one requester, drives its route, waits for
// valve settling, holds for the dwell time, then releases. Define FLOW_ROUTE_PURGE_EN for a purge gap.
module flow_route_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_SW     = 8,
  parameter int SEL_W      = 2,
  parameter int TIMER_W    = 16,
  parameter int SETTLE_CYC = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*NUM_SW*SEL_W-1:0]   req_route,
  input  logic [NUM_REQ*NUM_SW-1:0]         req_sw_mask,
  input  logic [NUM_REQ*TIMER_W-1:0]        req_dwell,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              route_ready,
  output logic [NUM_REQ-1:0]                done,
  output logic [NUM_SW*SEL_W-1:0]           sw_sel,
  output logic [NUM_SW-1:0]                 sw_en,
  output logic                              busy
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ROUTE_W = NUM_SW * SEL_W;
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYC);
  localparam logic [TIMER_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_DWELL,
    S_RELEASE,
    S_PURGE
  } state_t;

  state_t               state_q, state_n;
  logic [TIMER_W-1:0]   cnt_q, cnt_n;
  logic [TIMER_W-1:0]   dwell_q, dwell_n;
  logic [IDX_W-1:0]     owner_q, owner_n;
  logic [IDX_W-1:0]     rr_q, rr_n;
  logic [NUM_REQ-1:0]   grant_n, done_n;
  logic                 ready_n, busy_n;
  logic [ROUTE_W-1:0]   sw_sel_n;
  logic [NUM_SW-1:0]    sw_en_n;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [ROUTE_W-1:0]   win_route, win_sel;
  logic [NUM_SW-1:0]    win_mask;
  logic [TIMER_W-1:0]   win_dwell;
  logic [TIMER_W-1:0]   dwell_eff, cnt_inc;
  logic [IDX_W-1:0]     owner_next;

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_valid && req[(int'(rr_q) + k) % NUM_REQ]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    win_route = req_route[int'(pick_idx)*ROUTE_W +: ROUTE_W];
    win_mask  = req_sw_mask[int'(pick_idx)*NUM_SW +: NUM_SW];
    win_dwell = req_dwell[int'(pick_idx)*TIMER_W +: TIMER_W];
    win_sel   = '0;
    for (int s = 0; s < NUM_SW; s++) begin
      if (win_mask[s]) win_sel[s*SEL_W +: SEL_W] = win_route[s*SEL_W +: SEL_W];
    end
  end

  assign dwell_eff  = (dwell_q == '0) ? TIMER_W'(1) : dwell_q;
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TIMER_W'(1);
  assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_n  = state_q;
    cnt_n    = cnt_q;
    dwell_n  = dwell_q;
    owner_n  = owner_q;
    rr_n     = rr_q;
    grant_n  = grant;
    done_n   = '0;
    ready_n  = route_ready;
    busy_n   = busy;
    sw_sel_n = sw_sel;
    sw_en_n  = sw_en;

    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_n  = S_SETTLE;
          cnt_n    = '0;
          dwell_n  = win_dwell;
          owner_n  = pick_idx;
          grant_n  = NUM_REQ'(1) << pick_idx;
          busy_n   = 1'b1;
          sw_sel_n = win_sel;
          sw_en_n  = win_mask;
        end
      end
      S_SETTLE, S_DWELL: begin
        if (!req[owner_q] || (state_q == S_DWELL && cnt_q >= dwell_eff)) begin
          // Normal end of dwell and owner abort share one release path.
          state_n  = S_RELEASE;
          done_n   = NUM_REQ'(1) << owner_q;
          grant_n  = '0;
          ready_n  = 1'b0;
          sw_sel_n = '0;
          sw_en_n  = '0;
          rr_n     = owner_next;
        end else if (state_q == S_SETTLE && cnt_q >= SETTLE_LAST) begin
          state_n = S_DWELL;
          cnt_n   = TIMER_W'(1);
          ready_n = 1'b1;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_RELEASE: begin
`ifdef FLOW_ROUTE_PURGE_EN
        state_n = S_PURGE;
        cnt_n   = TIMER_W'(1);
`else
        state_n = S_IDLE;
        busy_n  = 1'b0;
`endif
      end
      S_PURGE: begin
        if (cnt_q >= SETTLE_LAST) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // NOTE: asynchronous reset drops every valve enable the instant rst_n falls, mid-operation included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dwell_q     <= '0;
      owner_q     <= '0;
      rr_q        <= '0;
      grant       <= '0;
      done        <= '0;
      route_ready <= 1'b0;
      busy        <= 1'b0;
      sw_sel      <= '0;
      sw_en       <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      dwell_q     <= dwell_n;
      owner_q     <= owner_n;
      rr_q        <= rr_n;
      grant       <= grant_n;
      done        <= done_n;
      route_ready <= ready_n;
      busy        <= busy_n;
      sw_sel      <= sw_sel_n;
      sw_en       <= sw_en_n;
    end
  end

endmodule
